// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined byte/half/word data memory with fixed READ_LAT response pipeline.
// Optional post-reset clear sweep of the array is enabled by defining DMEM_CLEAR_EN.
module dmem_pipe #(
  parameter int DEPTH_WORDS = 64,
  parameter int READ_LAT    = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        err_sticky
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS) << 2;

  localparam logic STATE_INIT = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          state_q, state_d;
  logic          err_sticky_q, err_sticky_d;

  logic          pipe_valid_q [READ_LAT];
  logic          pipe_valid_d [READ_LAT];
  logic          pipe_err_q   [READ_LAT];
  logic          pipe_err_d   [READ_LAT];
  logic [31:0]   pipe_rdata_q [READ_LAT];
  logic [31:0]   pipe_rdata_d [READ_LAT];

  logic          accept;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;

`ifdef DMEM_CLEAR_EN
  logic [AW-1:0] clr_idx_q, clr_idx_d;
`endif

  assign word_idx  = req_addr[AW+1:2];
  assign lane      = req_addr[1:0];
  assign rd_word   = mem_q[word_idx];
  assign req_ready = (state_q == STATE_RUN);
  assign accept    = req_valid & req_ready;

  // Error priority: illegal size, then alignment, then range.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3) begin
      req_err = 1'b1;
    end else if ((req_size == SIZE_HALF) && req_addr[0]) begin
      req_err = 1'b1;
    end else if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end else if (req_addr >= ADDR_LIMIT) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    byte_sel  = rd_word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (req_size)
      SIZE_BYTE: load_data = {{24{req_signed & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{req_signed & half_sel[15]}}, half_sel};
      default:   load_data = rd_word;
    endcase
  end

  // Read-modify-write merge keeps the untouched lanes of the word.
  always_comb begin
    store_word = rd_word;
    case (req_size)
      SIZE_BYTE: store_word[{lane, 3'b000} +: 8] = req_wdata[7:0];
      SIZE_HALF: begin
        if (lane[1]) begin
          store_word[31:16] = req_wdata[15:0];
        end else begin
          store_word[15:0] = req_wdata[15:0];
        end
      end
      SIZE_WORD: store_word = req_wdata;
      default:   store_word = rd_word;
    endcase
  end

  always_comb begin
    mem_we    = accept & req_we & ~req_err;
    mem_idx   = word_idx;
    mem_wdata = store_word;
`ifdef DMEM_CLEAR_EN
    if (state_q == STATE_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx_q;
      mem_wdata = 32'h0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
`ifdef DMEM_CLEAR_EN
    clr_idx_d = clr_idx_q;
    if (state_q == STATE_INIT) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
        state_d = STATE_RUN;
      end
    end
`endif
  end

  // Stage 0 captures the load result at the accept edge, so later stores cannot disturb it.
  always_comb begin
    pipe_valid_d[0] = accept;
    pipe_err_d[0]   = accept & req_err;
    pipe_rdata_d[0] = (accept && !req_we && !req_err) ? load_data : 32'h0;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
      pipe_rdata_d[i] = pipe_rdata_q[i-1];
    end
    err_sticky_d = err_sticky_q |
                   (pipe_valid_d[READ_LAT-1] & pipe_err_d[READ_LAT-1]);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
`ifdef DMEM_CLEAR_EN
      state_q   <= STATE_INIT;
      clr_idx_q <= '0;
`else
      state_q   <= STATE_RUN;
`endif
      err_sticky_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_err_q[i]   <= 1'b0;
        pipe_rdata_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
`ifdef DMEM_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
      err_sticky_q <= err_sticky_d;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_err_q[i]   <= pipe_err_d[i];
        pipe_rdata_q[i] <= pipe_rdata_d[i];
      end
    end
  end

  // The array itself is never reset; only the optional sweep clears it.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign resp_valid = pipe_valid_q[READ_LAT-1];
  assign resp_err   = pipe_err_q[READ_LAT-1];
  assign resp_rdata = pipe_rdata_q[READ_LAT-1];
  assign err_sticky = err_sticky_q;

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, pipelined data memory for the MIPS pipeline, replacing the single-cycle 32-word data RAM behind the core's load/store stage. It accepts one request per cycle through a valid/ready handshake, supports byte, halfword and word stores and loads with sign or zero extension, and returns a response a fixed `READ_LAT` cycles later. Misaligned and out-of-range accesses are flagged rather than silently aliased. An optional post-reset clear sweep initialises the array.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, minimum 4.
- `READ_LAT`, 1: response latency in cycles; legal range 1..4.
- `CLK` input 1: single clock; all state updates on rising edge.
- `RESET_N` input 1: reset, asynchronous assert, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: access size; 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle pulse per accepted request.
- `resp_err` output 1: qualifies `resp_valid`; access was rejected.
- `resp_rdata` output 32: load result, extended; 0 for stores and errors.
- `err_sticky` output 1: set by any error response, cleared only by reset.

## Operation
- States: `INIT` (clear sweep, only with `DMEM_CLEAR_EN`) and `RUN`.
- `req_ready` is 1 in `RUN`, 0 in `INIT`. There is no response backpressure, so `RUN` accepts a request every cycle.
- A request is accepted on a rising edge with `req_valid && req_ready`.
- Word index is `req_addr[log2(DEPTH_WORDS)+1:2]`. Byte lane is `req_addr[1:0]`.
- Error conditions, checked in order:
  - `req_size==3`.
  - Half access with `addr[0]==1`.
  - Word access with `addr[1:0]!=0`.
  - `req_addr >= 4*DEPTH_WORDS`.
- An erroring request never modifies the array. Its response carries `resp_err=1` and `resp_rdata=0`.
- Stores write only the addressed lanes. Byte lane n takes `wdata[7:0]`; a half at lane 0 or 2 takes `wdata[15:0]`. Other bytes of the word are preserved.
- Loads read the word at the accept edge and select the addressed lane(s): byte from lane `addr[1:0]`, half from lane 0 or 2. The result is extended per `req_signed` and word results pass through unchanged.
- Ordering:
  - Array reads and writes both occur at the accept edge, so a load accepted the cycle after a store to the same word returns the new data.
  - A later store never alters the result of an earlier, still-in-flight load.
- Responses are delivered in acceptance order through a `READ_LAT`-stage shift pipeline carrying valid, err and rdata.

## Timing
- Reset (`RESET_N` low), asynchronous:
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `err_sticky=0`.
  - All pipeline valid bits cleared.
  - State goes to `INIT` (macro defined) or `RUN` (undefined).
  - With the macro undefined, `req_ready` is 1 in the first cycle after release.
- Reset mid-operation: in-flight responses are discarded and never emitted, and an in-progress clear sweep restarts from word 0. The array is not reset except by the sweep.
- Latency: a request accepted at edge T produces `resp_valid=1` in the cycle following edge `T+READ_LAT-1`. With `READ_LAT=1` the response is high in the cycle directly after acceptance.
- Throughput: 1 request per cycle in `RUN`. Back-to-back accepts yield back-to-back response pulses.
- `err_sticky` rises in the same cycle as the erroring `resp_valid`.

## Configuration
- `DMEM_CLEAR_EN` defined:
  - After reset release, `INIT` writes 0 to word 0..`DEPTH_WORDS-1`, one word per cycle.
  - `req_ready` stays 0 for exactly `DEPTH_WORDS` cycles, then the block enters `RUN`.
  - `req_valid` during `INIT` is ignored and remains pending.
- `DMEM_CLEAR_EN` undefined: no `INIT` state; array contents are undefined until written.

## Test plan
- **Clear sweep:** `DMEM_CLEAR_EN`, DEPTH=64, release reset, hold `req_valid` with a word load of 0x10.
  - `req_ready` is 0 for 64 cycles.
  - The load is then accepted and returns `resp_rdata=0x00000000`, `resp_err=0`.
- **Store/load widths:**
  - Word store 0x11223344 to 0x8, then byte store 0xAA to 0x9.
  - Word load of 0x8 returns 0x1122AA44.
  - Signed half load of 0xA returns 0x00001122; signed byte load of 0x9 returns 0xFFFFFFAA.
- **Back-to-back latency:** `READ_LAT=3`, store then load of the same word on consecutive edges.
  - `resp_valid` is high for 2 consecutive cycles, starting in the cycle after accept edge +2.
  - The load returns the stored value.
- **Errors:**
  - Word store to 0x6 returns `resp_err=1`, `rdata=0`, `err_sticky=1`, and the word at 0x4 is unchanged.
  - A load of 0x100 with DEPTH=64 returns `resp_err=1`.
  - `req_size=3` returns `resp_err=1`.
- **Reset mid-flight:** `READ_LAT=4`, accept 2 loads, assert `RESET_N` low after 1 cycle.
  - Outputs go to 0 immediately.
  - No response pulses occur after release.
